// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared FSM state type and default divide-ratio width for clk_tick_ctrl
package clk_tick_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/clk_tick_ctrl.sv
// clk_tick_ctrl: start/stop periodic tick generator with safe ratio reload; CLK_TICK_CTRL_CNT_EN adds a 32-bit tick_cnt output
module clk_tick_ctrl
  import clk_tick_pkg::*;
#(
  parameter int               DIV_W     = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             busy
`ifdef CLK_TICK_CTRL_CNT_EN
  ,
  output logic [31:0]      tick_cnt
`endif
);
  state_t             r_state, w_next;
  logic [DIV_W-1:0]   r_cnt, r_div_q, r_pend_div;
  logic               r_pend_v;
  logic               w_accept;
  assign w_accept = cfg_valid && cfg_ready;
  // state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // next state: a stop landing on a tick cycle ends at once; start in STOPPING cancels the stop
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = start ? RUN : IDLE;
      RUN:      w_next = stop ? (tick ? IDLE : STOPPING) : RUN;
      STOPPING: w_next = start ? RUN : (tick ? IDLE : STOPPING);
      default:  w_next = IDLE;
    endcase
  end
  // outputs decoded from registers only
  always_comb begin
    busy      = r_state != IDLE;
    tick      = busy && (r_cnt == r_div_q);
    cfg_ready = !r_pend_v;
  end
  // period counter and ratio reload; div_q only changes while idle or on the edge closing a tick cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div_q    <= DIV_RESET;
      r_pend_div <= '0;
      r_pend_v   <= 1'b0;
    end else begin
      r_cnt <= (busy && !tick) ? r_cnt + DIV_W'(1) : '0;
      if (r_pend_v && (!busy || tick)) begin
        r_div_q  <= r_pend_div;
        r_pend_v <= 1'b0;
      end else if (w_accept && tick) begin
        r_div_q <= cfg_div;
      end else if (w_accept) begin
        r_pend_div <= cfg_div;
        r_pend_v   <= 1'b1;
      end
    end
  end
`ifdef CLK_TICK_CTRL_CNT_EN
  logic [31:0] r_tick_cnt;
  assign tick_cnt = r_tick_cnt;
  // free-running wrap-around count of ticks, cleared when a new run starts
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && start)) r_tick_cnt <= '0;
    else if (tick) r_tick_cnt <= r_tick_cnt + 32'd1;
  end
`endif
endmodule
